// File: rtl/alu_pkg.sv
// Shared encodings for the KGP-RISC ALU control path: ALUOp classes,
// ALU operation selects and the R-type one-hot function field.
package alu_pkg;

    localparam logic [2:0] ALUOP_RTYPE  = 3'd0;
    localparam logic [2:0] ALUOP_ADDI   = 3'd1;
    localparam logic [2:0] ALUOP_COMPI  = 3'd2;
    localparam logic [2:0] ALUOP_ANDI   = 3'd3;
    localparam logic [2:0] ALUOP_XORI   = 3'd4;
    localparam logic [2:0] ALUOP_BRANCH = 3'd5;
    localparam logic [2:0] ALUOP_CMP    = 3'd6;
    localparam logic [2:0] ALUOP_RSVD   = 3'd7;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_COMP = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_SHLL = 3'd4;
    localparam logic [2:0] OP_SHRL = 3'd5;
    localparam logic [2:0] OP_SHRA = 3'd6;

    localparam logic [6:0] FN_ADD  = 7'h01;
    localparam logic [6:0] FN_COMP = 7'h02;
    localparam logic [6:0] FN_AND  = 7'h04;
    localparam logic [6:0] FN_XOR  = 7'h08;
    localparam logic [6:0] FN_SHLL = 7'h10;
    localparam logic [6:0] FN_SHRL = 7'h20;
    localparam logic [6:0] FN_SHRA = 7'h40;

    localparam int VSHIFT_BIT = 7;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHLL) || (op == OP_SHRL) || (op == OP_SHRA);
    endfunction

endpackage

// File: rtl/alu_control_if.sv
// Decoder-to-ALU control bundle: the decoder side drives ALUOp/func_code,
// the ALU-control side returns op/shift_src/illegal.
interface alu_control_if;
    // No valid/ready: inputs are sampled every rising edge and outputs are
    // always meaningful (registered: one cycle later; combinational: same cycle).
    logic [2:0] ALUOp;
    logic [7:0] func_code;
    logic [2:0] op;
    logic       shift_src;
    logic       illegal;

    modport master (output ALUOp, output func_code,
                    input  op, input shift_src, input illegal);
    modport slave  (input  ALUOp, input func_code,
                    output op, output shift_src, output illegal);
endinterface

// File: rtl/alu_func_decode.sv
// Combinational R-type decoder: one-hot func_code[6:0] selects the operation,
// func_code[7] requests a register-sourced shift amount.
module alu_func_decode
    import alu_pkg::*;
(
    input  logic [7:0] func_code,
    output logic [2:0] op,
    output logic       shift_src,
    output logic       illegal
);

    logic var_shift;
    assign var_shift = func_code[VSHIFT_BIT];

    always_comb begin
        op        = OP_ADD;
        shift_src = 1'b0;
        illegal   = 1'b0;
        case (func_code[6:0])
            FN_ADD:  op = OP_ADD;
            FN_COMP: op = OP_COMP;
            FN_AND:  op = OP_AND;
            FN_XOR:  op = OP_XOR;
            FN_SHLL: op = OP_SHLL;
            FN_SHRL: op = OP_SHRL;
            FN_SHRA: op = OP_SHRA;
            default: illegal = 1'b1;
        endcase
        // The modifier only means something on shifts; elsewhere it is a bad encoding.
        if (is_shift_op(op))
            shift_src = var_shift;
        else if (var_shift)
            illegal = 1'b1;
    end

endmodule

// File: rtl/alu_control.sv
// ALU control: R-type func decode or ALUOp-class mapping, optionally
// registered with a synchronous active-high reset.
module alu_control
    import alu_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    alu_control_if.slave   bus
);

    logic [2:0] r_op;
    logic       r_shift_src;
    logic       r_illegal;
    logic [2:0] d_op;
    logic       d_shift_src;
    logic       d_illegal;

    alu_func_decode u_func_decode (
        .func_code (bus.func_code),
        .op        (r_op),
        .shift_src (r_shift_src),
        .illegal   (r_illegal)
    );

    always_comb begin
        d_op        = OP_ADD;
        d_shift_src = 1'b0;
        d_illegal   = 1'b0;
        case (bus.ALUOp)
            ALUOP_RTYPE: begin
                d_op        = r_op;
                d_shift_src = r_shift_src;
                d_illegal   = r_illegal;
            end
            ALUOP_ADDI:   d_op = OP_ADD;
            ALUOP_COMPI:  d_op = OP_COMP;
            ALUOP_ANDI:   d_op = OP_AND;
            ALUOP_XORI:   d_op = OP_XOR;
            ALUOP_BRANCH: d_op = OP_ADD;
            ALUOP_CMP:    d_op = OP_XOR;
            default:      d_illegal = 1'b1;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [2:0] op_q;
            logic       shift_src_q;
            logic       illegal_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_q        <= OP_ADD;
                    shift_src_q <= 1'b0;
                    illegal_q   <= 1'b0;
                end else begin
                    op_q        <= d_op;
                    shift_src_q <= d_shift_src;
                    illegal_q   <= d_illegal;
                end
            end

            assign bus.op        = op_q;
            assign bus.shift_src = shift_src_q;
            assign bus.illegal   = illegal_q;
        end else begin : g_comb
            assign bus.op        = d_op;
            assign bus.shift_src = d_shift_src;
            assign bus.illegal   = d_illegal;
        end
    endgenerate

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control (REG_OUT=1): the driver pushes the expected
// {op, shift_src, illegal} per cycle, the monitor pops it one edge later.
module tb_alu_control;

    logic clk;
    logic rst;

    alu_control_if bus ();

    alu_control #(.REG_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    string      name_q[$];
    int         chk_cnt;
    int         pass_cnt;

    function automatic logic [4:0] pack(input logic [2:0] op, input logic sh, input logic il);
        return {op, sh, il};
    endfunction

    // Driver: hold one input set for n cycles, one expected entry per cycle.
    task automatic drive(input string name, input logic r, input logic [2:0] aluop,
                         input logic [7:0] fc, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = r;
            bus.ALUOp     = aluop;
            bus.func_code = fc;
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
    endtask

    // Monitor: outputs are valid every cycle, checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [4:0] e;
                logic [4:0] a;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {bus.op, bus.shift_src, bus.illegal};
                chk_cnt++;
                if (a === e)
                    pass_cnt++;
                else
                    $display("FAIL %s: got op=%0d shift_src=%0b illegal=%0b, expected op=%0d shift_src=%0b illegal=%0b",
                             nm, a[4:2], a[1], a[0], e[4:2], e[1], e[0]);
            end
        end
    end

    initial begin
        logic [7:0] rt_fc [7];
        logic [7:0] ill_fc[3];
        logic [2:0] nr_op [8];
        chk_cnt  = 0;
        pass_cnt = 0;
        rst           = 1'b1;
        bus.ALUOp     = 3'd0;
        bus.func_code = 8'h08;

        // Reset, then release into XOR
        drive("reset",        1'b1, 3'd0, 8'h08, pack(3'd0, 1'b0, 1'b0), 2);
        drive("post_reset",   1'b0, 3'd0, 8'h08, pack(3'd3, 1'b0, 1'b0), 1);

        // R-type one-hot sweep, 10-cycle hold per step
        rt_fc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        for (int k = 0; k < 7; k++)
            drive($sformatf("rtype_%02h", rt_fc[k]), 1'b0, 3'd0, rt_fc[k],
                  pack(3'(k), 1'b0, 1'b0), 10);

        // Variable shifts and misused modifier
        drive("vshift_90", 1'b0, 3'd0, 8'h90, pack(3'd4, 1'b1, 1'b0), 3);
        drive("vshift_a0", 1'b0, 3'd0, 8'hA0, pack(3'd5, 1'b1, 1'b0), 3);
        drive("vshift_c0", 1'b0, 3'd0, 8'hC0, pack(3'd6, 1'b1, 1'b0), 3);
        drive("vmod_81",   1'b0, 3'd0, 8'h81, pack(3'd0, 1'b0, 1'b1), 3);
        drive("vmod_88",   1'b0, 3'd0, 8'h88, pack(3'd3, 1'b0, 1'b1), 2);

        // Non-one-hot R-type encodings
        ill_fc = '{8'h80, 8'h00, 8'h03};
        for (int k = 0; k < 3; k++)
            drive($sformatf("illegal_%02h", ill_fc[k]), 1'b0, 3'd0, ill_fc[k],
                  pack(3'd0, 1'b0, 1'b1), 3);
        drive("illegal_60", 1'b0, 3'd0, 8'h60, pack(3'd0, 1'b0, 1'b1), 2);

        // Non-R ALUOp sweep, func_code ignored
        nr_op = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd3, 3'd0};
        for (int k = 1; k < 8; k++)
            drive($sformatf("aluop_%0d", k), 1'b0, 3'(k), 8'h80,
                  pack(nr_op[k], 1'b0, (k == 7)), 3);
        drive("aluop_6_fc90", 1'b0, 3'd6, 8'h90, pack(3'd3, 1'b0, 1'b0), 2);

        // Mid-stream reset
        drive("mid_pre",   1'b0, 3'd2, 8'h00, pack(3'd1, 1'b0, 1'b0), 2);
        drive("mid_rst",   1'b1, 3'd2, 8'h00, pack(3'd0, 1'b0, 1'b0), 1);
        drive("mid_post",  1'b0, 3'd2, 8'h00, pack(3'd1, 1'b0, 1'b0), 3);

        // Drain with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
